// File: rtl/hit_reducer_pkg.sv
// hit_reducer_pkg: shared Q16.16 types, constants and state encoding for the hit reducer.
package hit_reducer_pkg;
  typedef logic signed [31:0] fip;
  localparam fip FIP_ONE = 32'sh0001_0000;
  localparam fip FIP_MIN = 32'sh8000_0000;
  localparam fip FIP_MAX = 32'sh7fff_ffff;
  localparam int CAND_IDX_W = 32;
  typedef struct packed {
    logic                  hit;
    fip                    t;
    logic [CAND_IDX_W-1:0] idx;
  } hit_cand_t;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
endpackage

// File: rtl/hit_min_tree.sv
// hit_min_tree: combinational reduction of NLANES lane results to the closest qualifying hit.
module hit_min_tree
  import hit_reducer_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int IDX_W  = 32,
  parameter fip MIN_T  = 0
) (
  input  logic [NLANES-1:0]       lane_valid,
  input  logic [NLANES-1:0]       lane_hit,
  input  logic [NLANES*32-1:0]    lane_t,
  input  logic [NLANES*IDX_W-1:0] lane_idx,
  input  fip                      t_max,
  output logic                    win_hit,
  output fip                      win_t,
  output logic [IDX_W-1:0]        win_idx
);
  fip               t_arr [NLANES];
  logic [IDX_W-1:0] i_arr [NLANES];
  logic [NLANES-1:0] qual;
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    assign t_arr[k] = lane_t[32*k +: 32];
    assign i_arr[k] = lane_idx[IDX_W*k +: IDX_W];
    assign qual[k]  = lane_valid[k] && lane_hit[k] && t_arr[k] >= MIN_T && t_arr[k] < t_max;
  end
  // Ascending lane scan with strict compares makes the lower lane win a full tie.
  always_comb begin
    win_hit = 1'b0;
    win_t   = FIP_MAX;
    win_idx = '0;
    for (int k = 0; k < NLANES; k++)
      if (qual[k] && (!win_hit || t_arr[k] < win_t || (t_arr[k] == win_t && i_arr[k] < win_idx))) begin
        win_hit = 1'b1;
        win_t   = t_arr[k];
        win_idx = i_arr[k];
      end
  end
endmodule

// File: rtl/hit_reducer.sv
// hit_reducer: batch closest-hit / any-hit reducer over NLANES intersection lanes,
// returning one held result per batch over a valid/ready handshake.
module hit_reducer
  import hit_reducer_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int IDX_W  = 32,
  parameter fip MIN_T  = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [IDX_W-1:0]        i_tri_cnt,
  input  logic                    i_any_hit,
  input  fip                      i_t_max,
  input  logic [NLANES-1:0]       i_lane_valid,
  input  logic [NLANES-1:0]       i_lane_hit,
  input  logic [NLANES*32-1:0]    i_lane_t,
  input  logic [NLANES*IDX_W-1:0] i_lane_idx,
  output logic                    o_busy,
  output logic                    o_abort,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic                    o_hit,
  output fip                      o_t,
  output logic [IDX_W-1:0]        o_tri_index,
  output logic                    o_err
);
  localparam int CW = $clog2(NLANES + 1);
  state_t           state;
  logic [IDX_W-1:0] rem, rem_nxt, n_ext, w_idx;
  logic [CW-1:0]    n;
  logic             any_reg, w_hit, upd, over;
  fip               t_max_reg, w_t;

  hit_min_tree #(.NLANES(NLANES), .IDX_W(IDX_W), .MIN_T(MIN_T)) u_tree (
    .lane_valid(i_lane_valid),
    .lane_hit  (i_lane_hit),
    .lane_t    (i_lane_t),
    .lane_idx  (i_lane_idx),
    .t_max     (t_max_reg),
    .win_hit   (w_hit),
    .win_t     (w_t),
    .win_idx   (w_idx)
  );

  always_comb begin
    n = '0;
    for (int k = 0; k < NLANES; k++) n = n + CW'(i_lane_valid[k]);
  end

  assign n_ext       = IDX_W'(n);
  assign over        = n_ext > rem;
  assign rem_nxt     = over ? '0 : rem - n_ext;
  assign upd         = w_hit && (!o_hit || w_t < o_t || (w_t == o_t && w_idx < o_tri_index));
  assign o_busy      = state == S_ACCUM;
  assign o_res_valid = state == S_DONE;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      rem         <= '0;
      any_reg     <= 1'b0;
      t_max_reg   <= '0;
      o_hit       <= 1'b0;
      o_t         <= FIP_MAX;
      o_tri_index <= '0;
      o_err       <= 1'b0;
      o_abort     <= 1'b0;
    end else if (i_start) begin
      state       <= i_tri_cnt != '0 ? S_ACCUM : S_DONE;
      rem         <= i_tri_cnt;
      any_reg     <= i_any_hit;
      t_max_reg   <= i_t_max;
      o_hit       <= 1'b0;
      o_t         <= FIP_MAX;
      o_tri_index <= '0;
      o_err       <= 1'b0;
      o_abort     <= 1'b0;
    end else if (state == S_ACCUM) begin
      if (upd) begin
        o_hit       <= 1'b1;
        o_t         <= w_t;
        o_tri_index <= w_idx;
      end
      rem <= rem_nxt;
      if (over) o_err <= 1'b1;
      if (any_reg && w_hit) o_abort <= 1'b1;
      if (rem_nxt == '0 || (any_reg && w_hit)) state <= S_DONE;
    end else if (state == S_DONE && i_res_ready) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: doc/hit_reducer.md
Name: hit_reducer

Overview:
Batch-level closest-hit / any-hit reducer. It sits behind NLANES parallel intersection pipelines inside the triangle-intersector wrapper. Per batch it consumes each lane's per-triangle result (valid, hit, t, triangle index), counts results against the batch size and tracks the minimum qualifying t. It returns a single held result over a valid/ready handshake. It generalises the single-lane, closest-only counter/compare loop with multiple lanes, a runtime any-hit (shadow-ray) mode with an upstream abort, a per-batch t window, deterministic tie-breaking and overrun detection.

Parameters:
NLANES, 4, number of parallel intersection lanes presented per cycle (1..16)
IDX_W, 32, width of triangle index and batch count
MIN_T, 0, signed Q16.16 lower bound; a hit requires t >= MIN_T

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset
i_start  in  1  one-cycle batch start; samples i_tri_cnt, i_any_hit, i_t_max
i_tri_cnt  in  IDX_W  number of results expected in the batch
i_any_hit  in  1  1 = finish on first qualifying hit
i_t_max  in  32  signed Q16.16 upper bound; a hit requires t < i_t_max
i_lane_valid  in  NLANES  per-lane result valid
i_lane_hit  in  NLANES  per-lane intersection result
i_lane_t  in  NLANES*32  per-lane signed t, lane k at bits [32k+31:32k]
i_lane_idx  in  NLANES*IDX_W  per-lane triangle index
o_busy  out  1  state is ACCUM
o_abort  out  1  any-hit satisfied; upstream must stop issuing triangles
o_res_valid  out  1  result available (state DONE)
i_res_ready  in  1  consumer accepts the result
o_hit  out  1  any qualifying hit occurred in the batch
o_t  out  32  minimum qualifying t; FIP_MAX if no hit
o_tri_index  out  IDX_W  index of the minimum hit; 0 if no hit
o_err  out  1  sticky overrun: more results arrived than i_tri_cnt

Behaviour:
- Reset: i_rstn is synchronous, active-low; clock is i_clk. On reset the state is IDLE and all outputs are 0, except o_t = FIP_MAX (32'sh7fffffff). Reset mid-batch discards the batch.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - i_start with i_tri_cnt != 0 -> ACCUM.
  - i_start with i_tri_cnt == 0 -> DONE, with o_hit=0, o_t=FIP_MAX, o_tri_index=0.
  - i_start in any state clears best-so-far, o_err and o_abort, and loads remaining = i_tri_cnt.
- i_start in ACCUM or DONE restarts the batch. The old result is dropped; no o_res_valid is issued for it.
- ACCUM, each cycle:
  - n = popcount(i_lane_valid), width $clog2(NLANES+1).
  - Lane k qualifies when valid & hit & t >= MIN_T & t < t_max_reg. All comparisons are signed.
  - The qualifying candidates are reduced combinationally to one (min t; tie on t -> lower index; tie on index -> lower lane).
  - The winner replaces the best if t < best_t, or t == best_t and idx < best_idx.
- Counting:
  - remaining -= n.
  - If n > remaining: set o_err, clamp remaining to 0.
  - remaining reaching 0 -> DONE on the next edge. That cycle's results are included.
- Latency: result registered; o_res_valid rises one cycle after the cycle delivering the final result.
- Any-hit mode:
  - The first cycle with any qualifying lane records the reduced winner of that cycle, sets o_abort and goes to DONE.
  - o_abort holds until the next i_start or reset.
  - Lane results arriving outside ACCUM are ignored. They never set o_err.
- DONE:
  - o_res_valid=1. o_hit, o_t and o_tri_index are stable.
  - i_res_ready -> IDLE on the next edge; outputs keep their values until the next i_start.
  - Simultaneous i_start and i_res_ready: the handshake completes and the new batch starts (start wins the state).
- Width: t is signed Q16.16, 32 bits. remaining is IDX_W bits unsigned and never wraps below 0.

Decomposition:
- Shared package entries:
  - fip typedef (signed 32-bit Q16.16)
  - FIP_ONE, FIP_MIN, FIP_MAX constants
  - hit_cand_t struct {logic hit; fip t; logic [IDX_W-1:0] idx;}
  - state enum
- Sub-module hit_min_tree:
  - combinational NLANES-input reduction tree
  - parameters NLANES, IDX_W, MIN_T
  - inputs: lane arrays and t_max
  - outputs: winner hit, t, idx
  - reused later by the BVH leaf unit

Test Plan:
- NLANES=4, start cnt=8, 2 cycles all-valid; hits t=0x30000 (idx5), 0x10000 (idx2), 0x10000 (idx7), t_max=FIP_MAX -> o_hit=1, o_t=0x10000, o_tri_index=2, o_res_valid 1 cycle after 2nd cycle.
- cnt=3, lanes 0,1 valid then lane 3 valid; no hits -> o_hit=0, o_t=FIP_MAX, idx=0, o_err=0.
- Any-hit: cnt=100, qualifying hit t=0x8000 idx9 at cycle 4 -> o_abort=1 next cycle, DONE with idx9; later lane results ignored, o_err=0.
- Window: t_max=0x20000, hits t=0x20000 and t=-0x100 (MIN_T=0) -> neither qualifies, o_hit=0.
- Overrun: cnt=2, a cycle with 3 valid lanes -> o_err=1, DONE next cycle; cnt=0 start -> o_res_valid next cycle, o_hit=0.
- Hold i_res_ready=0 for 5 cycles -> outputs stable; assert reset mid-ACCUM -> next cycle IDLE, o_res_valid=0, o_t=FIP_MAX.
